keypad_scanner: RTL and testbench

//  Matrix-scan driver for the 4x4 hex keypad (1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D).

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/sync2.sv | 24 ++
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and the key code map for the 4x4 hex keypad scanner.
package keypad_pkg;

    // Column strobe seen after reset; later strobes are this shifted by the column index.
    localparam logic [3:0] COL_FIRST = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_REL_WAIT
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } res_class_t;

    // Keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D (row 0 on top, column 0 on left).
    function automatic logic [3:0] hex_code(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h4;
            4'h2:    code = 4'h7;
            4'h3:    code = 4'hE;
            4'h4:    code = 4'h2;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h8;
            4'h7:    code = 4'h0;
            4'h8:    code = 4'h3;
            4'h9:    code = 4'h6;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hF;
            4'hC:    code = 4'hA;
            4'hD:    code = 4'hB;
            4'hE:    code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous keypad row lines.
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Double-register the raw inputs; both stages clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix scanner for the 4x4 hex keypad: column strobing, row sampling,
// whole-scan debouncing and single press events with hex codes.
module keypad_scanner import keypad_pkg::*; #(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows_in,
    output logic [3:0] cols_out,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       rows_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             slot_last;
    logic             scan_done;
    logic [15:0]      acc;
    logic [15:0]      scan_map;
    logic [4:0]       ones;
    logic [3:0]       hit_idx;
    res_class_t       res_cls;
    logic [3:0]       res_code;
    res_class_t       prev_cls;
    logic [3:0]       prev_code;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stable;
    state_t           state;
    state_t           state_nxt;
    logic             fire;

    sync2 #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rows_in),
        .q   (rows_s)
    );

    assign slot_last = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign scan_done = slot_last && (col_idx == 2'd3);
    assign cols_out  = COL_FIRST << col_idx;
    assign key_held  = (state == ST_HELD) || (state == ST_REL_WAIT);

    // Column slot timer: hold each strobe SCAN_DIV cycles, then advance the column.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            col_idx <= '0;
        end else if (slot_last) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Current scan map with this column's live sample merged in, so the column-3
    // sample cycle sees the complete scan without waiting a cycle.
    always_comb begin
        scan_map = acc;
        scan_map[{col_idx, 2'b00} +: 4] = rows_s;
    end

    // Classify the scan map as none / single / multi and decode a single hit.
    always_comb begin
        ones    = '0;
        hit_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (scan_map[i]) begin
                ones    = ones + 5'd1;
                hit_idx = 4'(i);
            end
        end
        if (ones == 5'd0) begin
            res_cls  = RES_NONE;
            res_code = 4'h0;
        end else if (ones == 5'd1) begin
            res_cls  = RES_SINGLE;
            res_code = hex_code(hit_idx[3:2], hit_idx[1:0]);
        end else begin
            res_cls  = RES_MULTI;
            res_code = 4'h0;
        end
    end

    // Next stability count: grows (saturating) while the scan result repeats.
    always_comb begin
        cnt_nxt = CNT_W'(1);
        if (res_cls == prev_cls && res_code == prev_code) begin
            if (stable_cnt == CNT_W'(DEBOUNCE_SCANS)) begin
                cnt_nxt = stable_cnt;
            end else begin
                cnt_nxt = stable_cnt + CNT_W'(1);
            end
        end
        stable = (cnt_nxt == CNT_W'(DEBOUNCE_SCANS));
    end

    // Accumulate column samples and record each completed scan's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            prev_cls   <= RES_NONE;
            prev_code  <= '0;
            stable_cnt <= '0;
        end else if (scan_done) begin
            acc        <= '0;
            prev_cls   <= res_cls;
            prev_code  <= res_code;
            stable_cnt <= cnt_nxt;
        end else if (slot_last) begin
            acc <= scan_map;
        end
    end

    // Debounce FSM next-state logic; only moves on scan-complete cycles.
    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        if (scan_done) begin
            case (state)
                ST_IDLE: begin
                    if (res_cls == RES_SINGLE) state_nxt = ST_PRESS_WAIT;
                end
                ST_PRESS_WAIT: begin
                    if (res_cls != RES_SINGLE) begin
                        state_nxt = ST_IDLE;
                    end else if (stable) begin
                        state_nxt = ST_HELD;
                        fire      = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!(res_cls == RES_SINGLE && res_code == key)) state_nxt = ST_REL_WAIT;
                end
                ST_REL_WAIT: begin
                    if (res_cls == RES_NONE && stable) begin
                        state_nxt = ST_IDLE;
                    end else if (res_cls == RES_SINGLE && res_code == key) begin
                        state_nxt = ST_HELD;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state, accepted key and the one-cycle press pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_valid <= fire;
            if (fire) key <= res_code;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows_in;
    logic [3:0] cols_out;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    // Pressed-key matrix: bit (col*4 + row).
    logic [15:0] keys = '0;

    localparam logic [15:0] K5 = 16'h0020; // col1 row1
    localparam logic [15:0] K9 = 16'h0400; // col2 row2
    localparam logic [15:0] K1 = 16'h0001; // col0 row0
    localparam logic [15:0] K6 = 16'h0200; // col2 row1
    localparam logic [15:0] K0 = 16'h0080; // col1 row3
    localparam logic [15:0] KD = 16'h8000; // col3 row3

    int tests_run = 0;
    int failed    = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .rows_in   (rows_in),
        .cols_out  (cols_out),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column strobe to its row line.
    always_comb begin
        rows_in = '0;
        for (int c = 0; c < 4; c++) begin
            if (cols_out[c]) rows_in = rows_in | keys[c*4 +: 4];
        end
    end

    // Observe outputs for a number of cycles (sampled #1 after each rising edge).
    task automatic watch(input int cycles, output int pulses, output logic [3:0] pkey,
                         output int first_at, output int held_lo, output int first_lo,
                         output int dbl);
        logic prev_kv;
        prev_kv  = 1'b0;
        pulses   = 0;
        pkey     = '0;
        first_at = -1;
        held_lo  = 0;
        first_lo = -1;
        dbl      = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin
                if (prev_kv) dbl++;
                pulses++;
                pkey = key;
                if (first_at < 0) first_at = i;
            end
            if (!key_held) begin
                held_lo++;
                if (first_lo < 0) first_lo = i;
            end
            prev_kv = key_valid;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_cols [4];
        exp_cols[0] = 4'b0010;
        exp_cols[1] = 4'b0100;
        exp_cols[2] = 4'b1000;
        exp_cols[3] = 4'b0001;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (cols_out !== 4'b0001) begin failed++; $display("FAIL reset_cols: got %b expected 0001", cols_out); end
        tests_run++; if (key !== 4'h0) begin failed++; $display("FAIL reset_key: got %h expected 0", key); end
        tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL reset_held: got %b expected 0", key_held); end
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            repeat (4) @(posedge clk);
            #1;
            tests_run++;
            if (cols_out !== exp_cols[s]) begin
                failed++;
                $display("FAIL col_step%0d: got %b expected %b", s, cols_out, exp_cols[s]);
            end
        end
    endtask

    task automatic test_clean_press;
        int p, fa, hl, fl, d;
        logic [3:0] pk;
        keys = K5;
        watch(96, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 1) begin failed++; $display("FAIL press5_pulses: got %0d expected 1", p); end
        tests_run++; if (pk !== 4'h5) begin failed++; $display("FAIL press5_key: got %h expected 5", pk); end
        tests_run++; if (fa < 1 || fa > 64) begin failed++; $display("FAIL press5_latency: got %0d cycles expected 1..64", fa); end
        tests_run++; if (key_held !== 1'b1) begin failed++; $display("FAIL press5_held: got %b expected 1", key_held); end
        tests_run++; if (d !== 0) begin failed++; $display("FAIL press5_double: got %0d expected 0", d); end
    endtask

    task automatic test_release;
        int p1, p2, fa, hl1, hl2, fl, d;
        logic [3:0] pk;
        keys = '0;
        watch(16, p1, pk, fa, hl1, fl, d);
        keys = K5;
        watch(64, p2, pk, fa, hl2, fl, d);
        tests_run++; if (hl1 + hl2 !== 0) begin failed++; $display("FAIL glitch_held: got %0d low cycles expected 0", hl1 + hl2); end
        tests_run++; if (p1 + p2 !== 0) begin failed++; $display("FAIL glitch_pulses: got %0d expected 0", p1 + p2); end
        keys = '0;
        watch(80, p1, pk, fa, hl1, fl, d);
        tests_run++; if (fl < 1 || fl > 64) begin failed++; $display("FAIL release_fall: got %0d cycles expected 1..64", fl); end
        tests_run++; if (key !== 4'h5) begin failed++; $display("FAIL release_key: got %h expected 5", key); end
        tests_run++; if (p1 !== 0) begin failed++; $display("FAIL release_pulses: got %0d expected 0", p1); end
    endtask

    task automatic test_bounce;
        int p, fa, hl, fl, d, tp, thl;
        logic [3:0] pk;
        tp  = 0;
        thl = 0;
        for (int r = 0; r < 4; r++) begin
            keys = K9;
            watch(16, p, pk, fa, hl, fl, d);
            tp += p; thl += hl;
            keys = '0;
            watch(16, p, pk, fa, hl, fl, d);
            tp += p; thl += hl;
        end
        watch(48, p, pk, fa, hl, fl, d);
        tp += p; thl += hl;
        tests_run++; if (tp !== 0) begin failed++; $display("FAIL bounce_pulses: got %0d expected 0", tp); end
        tests_run++; if (thl !== 176) begin failed++; $display("FAIL bounce_held: got %0d low cycles expected 176", thl); end
    endtask

    task automatic test_multi_then_zero;
        int p, fa, hl, fl, d;
        logic [3:0] pk;
        keys = K1 | K6;
        watch(96, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 0) begin failed++; $display("FAIL multi_pulses: got %0d expected 0", p); end
        keys = '0;
        watch(64, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 0) begin failed++; $display("FAIL multi_release_pulses: got %0d expected 0", p); end
        keys = K0;
        watch(64, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 1) begin failed++; $display("FAIL press0_pulses: got %0d expected 1", p); end
        tests_run++; if (pk !== 4'h0) begin failed++; $display("FAIL press0_key: got %h expected 0", pk); end
        watch(32, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 0 || hl !== 0) begin failed++; $display("FAIL press0_hold: got pulses=%0d low=%0d expected 0/0", p, hl); end
        keys = '0;
        watch(80, p, pk, fa, hl, fl, d);
        tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL press0_release: got %b expected 0", key_held); end
    endtask

    task automatic test_reset_midop;
        int p, fa, hl, fl, d;
        logic [3:0] pk;
        keys = KD;
        watch(24, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 0) begin failed++; $display("FAIL pw_prepulse: got %0d expected 0", p); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (cols_out !== 4'b0001) begin failed++; $display("FAIL pw_rst_cols: got %b expected 0001", cols_out); end
        tests_run++; if (key !== 4'h0) begin failed++; $display("FAIL pw_rst_key: got %h expected 0", key); end
        tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL pw_rst_valid: got %b expected 0", key_valid); end
        tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL pw_rst_held: got %b expected 0", key_held); end
        rst = 1'b0;
        watch(80, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 1) begin failed++; $display("FAIL d1_pulses: got %0d expected 1", p); end
        tests_run++; if (pk !== 4'hD) begin failed++; $display("FAIL d1_key: got %h expected d", pk); end
        tests_run++; if (key_held !== 1'b1) begin failed++; $display("FAIL d1_held: got %b expected 1", key_held); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (cols_out !== 4'b0001) begin failed++; $display("FAIL held_rst_cols: got %b expected 0001", cols_out); end
        tests_run++; if (key !== 4'h0) begin failed++; $display("FAIL held_rst_key: got %h expected 0", key); end
        tests_run++; if (key_valid !== 1'b0) begin failed++; $display("FAIL held_rst_valid: got %b expected 0", key_valid); end
        tests_run++; if (key_held !== 1'b0) begin failed++; $display("FAIL held_rst_held: got %b expected 0", key_held); end
        rst = 1'b0;
        watch(80, p, pk, fa, hl, fl, d);
        tests_run++; if (p !== 1) begin failed++; $display("FAIL d2_pulses: got %0d expected 1", p); end
        tests_run++; if (pk !== 4'hD) begin failed++; $display("FAIL d2_key: got %h expected d", pk); end
        tests_run++; if (fa < 40 || fa > 64) begin failed++; $display("FAIL d2_latency: got %0d cycles expected 40..64", fa); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_multi_then_zero();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
